seq_arith_8b_sla_iter: RTL and testbench

Iterative 8-bit arithmetic left shifter. It shifts one bit position per cycle and reports signed overflow. It is the left-direction counterpart to the team's 8-bit combinational arithmetic right shifter, with latency-insensitive val/rdy streams on input and output. It is used where a multi-cycle, area-cheap shifter with overflow detection is preferred over a barrel shifter.

---
 rtl/seq_arith_8b_sla_iter.sv | 122 ++++++++++++
 tb/tb_seq_arith_8b_sla_iter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_8b_sla_iter.sv
// ----------------------------------------------------------------------------
// seq_arith_8b_sla_iter
//
// Iterative 8-bit arithmetic left shifter with signed overflow detection.
// It shifts the operand left by one bit position per clock cycle. Requests
// and results use latency-insensitive val/rdy handshakes. Only one
// transaction is in flight at a time.
//
// Ports:
//   clk          in   1  clock; all state updates on the rising edge
//   reset        in   1  asynchronous, active-high reset
//   istream_val  in   1  request valid
//   istream_rdy  out  1  block can accept a request (IDLE, not in reset)
//   in_          in   8  operand, two's-complement
//   amt          in   3  left shift amount, 0..7
//   ostream_val  out  1  result valid (DONE)
//   ostream_rdy  in   1  consumer can accept the result
//   out          out  8  low 8 bits of in_ << amt
//   ovf          out  1  in_ * 2^amt does not fit in 8-bit two's-complement
// ----------------------------------------------------------------------------
module seq_arith_8b_sla_iter (
   input  logic       clk,
   input  logic       reset,
   input  logic       istream_val,
   output logic       istream_rdy,
   input  logic [7:0] in_,
   input  logic [2:0] amt,
   output logic       ostream_val,
   input  logic       ostream_rdy,
   output logic [7:0] out,
   output logic       ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [2:0] count_reg;
   logic [7:0] shift_reg;
   logic       ovf_reg;
   logic       accept;
   logic       deliver;

   // The handshakes that move the FSM. A request is only taken in IDLE. A
   // result only leaves in DONE. Holding istream_rdy low during reset means
   // a producer never sees a false accept window while the block is held.
   always_comb begin
      istream_rdy = (state_reg == IDLE) && !reset;
      ostream_val = (state_reg == DONE);
      accept      = istream_val && istream_rdy;
      deliver     = ostream_val && ostream_rdy;
   end

   // State register. Reset is asynchronous, so an in-flight transaction is
   // dropped the moment reset rises, without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic. A zero shift amount skips CALC entirely, so the
   // result is valid in the cycle right after acceptance. Otherwise CALC
   // runs exactly amt cycles. It leaves on the step where the count was 1.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (amt == 3'd0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (count_reg == 3'd1) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (deliver) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath. Each CALC step first checks whether the bit about to move
   // into the sign position differs from the current sign bit. If so, the
   // value has left the representable range. That flag is sticky until the
   // next accept. Zeros always shift in from the right. The registers hold
   // their value in IDLE and DONE, so the result stays stable under
   // backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= 3'd0;
         shift_reg <= 8'h00;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         count_reg <= amt;
         shift_reg <= in_;
         ovf_reg   <= 1'b0;
      end else if (state_reg == CALC) begin
         count_reg <= count_reg - 3'd1;
         shift_reg <= {shift_reg[6:0], 1'b0};
         ovf_reg   <= ovf_reg | (shift_reg[7] ^ shift_reg[6]);
      end
   end

   // Outputs come straight from the registers. They are only meaningful
   // while ostream_val is high.
   always_comb begin
      out = shift_reg;
      ovf = ovf_reg;
   end

endmodule

// File: tb/tb_seq_arith_8b_sla_iter.sv
// ----------------------------------------------------------------------------
// tb_seq_arith_8b_sla_iter
//
// Self-checking directed bench for the iterative arithmetic left shifter.
// Each test task drives its own stimulus and compares the observed values
// against hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_seq_arith_8b_sla_iter;

   logic       clk;
   logic       reset;
   logic       istream_val;
   logic       istream_rdy;
   logic [7:0] in_;
   logic [2:0] amt;
   logic       ostream_val;
   logic       ostream_rdy;
   logic [7:0] out;
   logic       ovf;

   int total;
   int bad;

   seq_arith_8b_sla_iter dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .in_         (in_),
      .amt         (amt),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .out         (out),
      .ovf         (ovf)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one request and waits for the result, with bounded waits.
   // After ostream_val rises, it holds ostream_rdy low for 'stall' cycles
   // and records whether the result stayed stable. Then it hands the result
   // off. The latency is counted in rising edges from the accept edge to
   // the first sample where ostream_val is high.
   task automatic run_txn(input logic [7:0] a_in, input logic [2:0] a_amt,
                          input int stall, output logic [7:0] r_out,
                          output logic r_ovf, output int r_lat,
                          output logic r_hold_ok, output logic r_timeout);
      int n;
      r_timeout = 1'b0;
      r_hold_ok = 1'b1;
      r_lat     = 0;
      ostream_rdy = 1'b0;
      @(negedge clk);
      in_ = a_in;
      amt = a_amt;
      istream_val = 1'b1;
      n = 0;
      while (!istream_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!istream_rdy) r_timeout = 1'b1;
      @(posedge clk);
      #1;
      istream_val = 1'b0;
      in_ = 8'h00;
      amt = 3'd0;
      r_lat = 1;
      while (!ostream_val && r_lat < 20) begin
         @(posedge clk);
         #1;
         r_lat++;
      end
      if (!ostream_val) r_timeout = 1'b1;
      r_out = out;
      r_ovf = ovf;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         if (!ostream_val || out !== r_out || ovf !== r_ovf || istream_rdy)
            r_hold_ok = 1'b0;
      end
      ostream_rdy = 1'b1;
      @(posedge clk);
      #1;
      ostream_rdy = 1'b0;
   endtask

   // Reset behaviour: while reset is high, the handshake outputs stay low
   // and the registers are cleared. After release, the block is ready.
   task automatic test_reset();
      reset = 1'b1;
      istream_val = 1'b1;
      ostream_rdy = 1'b1;
      in_ = 8'hA5;
      amt = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (istream_rdy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_istream_rdy got=%b want=0", istream_rdy);
      end
      total++;
      if (ostream_val !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_ostream_val got=%b want=0", ostream_val);
      end
      total++;
      if (out !== 8'h00 || ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_regs got out=%h ovf=%b want out=00 ovf=0",
                  out, ovf);
      end
      istream_val = 1'b0;
      ostream_rdy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (istream_rdy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL post_reset_rdy got=%b want=1", istream_rdy);
      end
   endtask

   // Directed shift vectors, including the overflow boundary at the sign
   // bit. The expected values were computed by hand.
   task automatic test_directed();
      logic [7:0] v_in  [10] = '{8'h5D, 8'h5D, 8'h5D, 8'hD5, 8'hD5,
                                 8'hFF, 8'h01, 8'h03, 8'h03, 8'h40};
      logic [2:0] v_amt [10] = '{3'd0, 3'd1, 3'd3, 3'd1, 3'd2,
                                 3'd7, 3'd7, 3'd5, 3'd6, 3'd1};
      logic [7:0] v_out [10] = '{8'h5D, 8'hBA, 8'hE8, 8'hAA, 8'h54,
                                 8'h80, 8'h80, 8'h60, 8'hC0, 8'h80};
      logic       v_ovf [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [7:0] g_out;
      logic       g_ovf;
      int         g_lat;
      logic       g_hold;
      logic       g_to;
      for (int i = 0; i < 10; i++) begin
         run_txn(v_in[i], v_amt[i], (i % 3), g_out, g_ovf, g_lat, g_hold, g_to);
         total++;
         if (g_to !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dir%0d_timeout got=timeout want=handshake", i);
         end
         total++;
         if (g_out !== v_out[i] || g_ovf !== v_ovf[i]) begin
            bad++;
            $display("[TB] FAIL dir%0d_result in=%h amt=%0d got out=%h ovf=%b want out=%h ovf=%b",
                     i, v_in[i], v_amt[i], g_out, g_ovf, v_out[i], v_ovf[i]);
         end
         total++;
         if (g_lat !== int'(v_amt[i]) + 1) begin
            bad++;
            $display("[TB] FAIL dir%0d_latency got=%0d want=%0d",
                     i, g_lat, int'(v_amt[i]) + 1);
         end
         total++;
         if (g_hold !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dir%0d_hold got=unstable want=stable", i);
         end
      end
   endtask

   // Backpressure in DONE. The result must stay put, and a request pulse
   // that arrives while busy must be ignored. After the hand-off, the next
   // request is served normally.
   task automatic test_backpressure();
      logic [7:0] g_out;
      logic       g_ovf;
      int         g_lat;
      logic       g_hold;
      logic       g_to;
      int         n;
      logic       held;
      ostream_rdy = 1'b0;
      @(negedge clk);
      in_ = 8'h11;
      amt = 3'd2;
      istream_val = 1'b1;
      @(posedge clk);
      #1;
      istream_val = 1'b0;
      n = 0;
      while (!ostream_val && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (ostream_val !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_val_timeout got=%b want=1", ostream_val);
      end
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            in_ = 8'h7F;
            amt = 3'd1;
            istream_val = 1'b1;
         end else begin
            istream_val = 1'b0;
         end
         @(posedge clk);
         #1;
         if (out !== 8'h44 || ovf !== 1'b0 || ostream_val !== 1'b1 ||
             istream_rdy !== 1'b0)
            held = 1'b0;
      end
      istream_val = 1'b0;
      total++;
      if (held !== 1'b1 || out !== 8'h44) begin
         bad++;
         $display("[TB] FAIL bp_hold got out=%h val=%b rdy=%b want out=44 val=1 rdy=0",
                  out, ostream_val, istream_rdy);
      end
      ostream_rdy = 1'b1;
      @(posedge clk);
      #1;
      ostream_rdy = 1'b0;
      total++;
      if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || out !== 8'h44) begin
         bad++;
         $display("[TB] FAIL bp_idle got rdy=%b val=%b out=%h want rdy=1 val=0 out=44",
                  istream_rdy, ostream_val, out);
      end
      run_txn(8'h7F, 3'd1, 0, g_out, g_ovf, g_lat, g_hold, g_to);
      total++;
      if (g_to !== 1'b0 || g_out !== 8'hFE || g_ovf !== 1'b1 || g_lat !== 2) begin
         bad++;
         $display("[TB] FAIL bp_next got out=%h ovf=%b lat=%0d to=%b want out=fe ovf=1 lat=2 to=0",
                  g_out, g_ovf, g_lat, g_to);
      end
   endtask

   // Reset between clock edges while CALC is running. It must take effect
   // at once, and the block must then serve a fresh request.
   task automatic test_reset_mid();
      logic [7:0] g_out;
      logic       g_ovf;
      int         g_lat;
      logic       g_hold;
      logic       g_to;
      ostream_rdy = 1'b1;
      @(negedge clk);
      in_ = 8'h81;
      amt = 3'd7;
      istream_val = 1'b1;
      @(posedge clk);
      #1;
      istream_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out !== 8'h04) begin
         bad++;
         $display("[TB] FAIL mid_progress got out=%h want=04", out);
      end
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (ostream_val !== 1'b0 || istream_rdy !== 1'b0 || out !== 8'h00) begin
         bad++;
         $display("[TB] FAIL mid_reset_async got val=%b rdy=%b out=%h want val=0 rdy=0 out=00",
                  ostream_val, istream_rdy, out);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_release got rdy=%b val=%b want rdy=1 val=0",
                  istream_rdy, ostream_val);
      end
      run_txn(8'h40, 3'd1, 0, g_out, g_ovf, g_lat, g_hold, g_to);
      total++;
      if (g_to !== 1'b0 || g_out !== 8'h80 || g_ovf !== 1'b1 || g_lat !== 2) begin
         bad++;
         $display("[TB] FAIL mid_next got out=%h ovf=%b lat=%0d to=%b want out=80 ovf=1 lat=2 to=0",
                  g_out, g_ovf, g_lat, g_to);
      end
   endtask

   // Back-to-back random transactions with random stalls, checked against
   // a reference model built from the full-width product and a bit scan.
   task automatic test_back_to_back();
      logic [7:0]  r_in;
      logic [2:0]  r_amt;
      logic [15:0] wide;
      logic [7:0]  e_out;
      logic        e_ovf;
      logic [7:0]  g_out;
      logic        g_ovf;
      int          g_lat;
      logic        g_hold;
      logic        g_to;
      for (int t = 0; t < 20; t++) begin
         r_in  = 8'($urandom_range(0, 255));
         r_amt = 3'($urandom_range(0, 7));
         wide  = {8'h00, r_in} << r_amt;
         e_out = wide[7:0];
         e_ovf = 1'b0;
         for (int b = 6; b >= 0; b--) begin
            if (b >= 7 - int'(r_amt) && r_in[b] != r_in[7]) e_ovf = 1'b1;
         end
         run_txn(r_in, r_amt, int'($urandom_range(0, 3)),
                 g_out, g_ovf, g_lat, g_hold, g_to);
         total++;
         if (g_to !== 1'b0 || g_out !== e_out || g_ovf !== e_ovf ||
             g_lat !== int'(r_amt) + 1 || g_hold !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rnd%0d in=%h amt=%0d got out=%h ovf=%b lat=%0d hold=%b to=%b want out=%h ovf=%b lat=%0d",
                     t, r_in, r_amt, g_out, g_ovf, g_lat, g_hold, g_to,
                     e_out, e_ovf, int'(r_amt) + 1);
         end
      end
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      total = 0;
      bad = 0;
      reset = 1'b0;
      istream_val = 1'b0;
      ostream_rdy = 1'b0;
      in_ = 8'h00;
      amt = 3'd0;
      $display("[TB] starting");
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
